// File: rtl/hash_table_ram_ctrl.sv
// hash_table_ram_ctrl: clear sequencer, write-port arbiter and pipelined lookup path for one SDP hash-table RAM.
// Latency: a lookup accepted in cycle N presents res_valid in cycle N+2; host updates write in their accept cycle.
// Backpressure: lkp_ready drops once two results are in flight or buffered; updates never stall on lookups.
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   upd_valid/ready, upd_addr/data host table update (written straight to the RAM write port)
//   lkp_valid/ready, lkp_addr      lookup request (issued straight to the RAM read port)
//   res_valid/ready, res_addr/data lookup result, in request order, held while stalled
//   init_req, init_busy, init_done table clear request (level), sweep/drain busy, sweep-complete pulse
//   ram_wr_*, ram_rd_*             simple dual-port RAM with 1-cycle registered read
//
// Build option: define BYPASS_FWD_EN to forward same-cycle update data to a lookup of the same
// address; without it such a lookup returns the RAM's pre-write (read-first) content.

// Small generic synchronous FIFO with registered storage; head is visible while head_vld is high.
module ht_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop_rdy,
    output logic             head_vld,
    output logic [WIDTH-1:0] head_dat,
    output logic [CW-1:0]    occ
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign do_pop   = pop_rdy && (cnt != '0);
    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign do_push  = push_vld && ((cnt != CW'(DEPTH)) || do_pop);
    assign head_vld = (cnt != '0);
    assign head_dat = mem[rd_ptr];
    assign occ      = cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage carries no reset; occupancy alone says what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end
endmodule

module hash_table_ram_ctrl #(
    parameter int                 DWIDTH     = 64,
    parameter int                 DEPTH      = 512,
    parameter int                 AW         = $clog2(DEPTH),
    parameter logic [DWIDTH-1:0]  INIT_VALUE = '0
) (
    input  logic              clk,
    input  logic              rst,
    // host updates
    input  logic              upd_valid,
    output logic              upd_ready,
    input  logic [AW-1:0]     upd_addr,
    input  logic [DWIDTH-1:0] upd_data,
    // lookups
    input  logic              lkp_valid,
    output logic              lkp_ready,
    input  logic [AW-1:0]     lkp_addr,
    // results
    output logic              res_valid,
    input  logic              res_ready,
    output logic [AW-1:0]     res_addr,
    output logic [DWIDTH-1:0] res_data,
    // table clear
    input  logic              init_req,
    output logic              init_busy,
    output logic              init_done,
    // RAM
    output logic              ram_wr_en,
    output logic [AW-1:0]     ram_wr_addr,
    output logic [DWIDTH-1:0] ram_wr_data,
    output logic              ram_rd_en,
    output logic [AW-1:0]     ram_rd_addr,
    input  logic [DWIDTH-1:0] ram_rd_data
);
    localparam logic [1:0] ST_INIT  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [AW-1:0]     sweep_cnt;
    logic              sweep_last;
    logic              init_done_q;

    logic              run_open;
    logic              upd_fire;
    logic              lkp_fire;
    logic              res_pop;
    logic [1:0]        occ;
    logic [2:0]        inflight;

    // Stage 1: read in flight, RAM data arrives in this cycle.
    logic              s1_valid;
    logic [AW-1:0]     s1_addr;
    logic [DWIDTH-1:0] s1_data;

    logic [AW+DWIDTH-1:0] fifo_head;

    // ------------------------------------------------------------------
    // Handshakes
    // ------------------------------------------------------------------
    // A pending clear request closes both request ports immediately so the
    // drain only has to wait for work that is already inside the pipeline.
    assign run_open  = (state == ST_RUN) && !init_req;
    assign upd_ready = run_open;
    assign upd_fire  = upd_valid && upd_ready;

    assign res_pop   = res_valid && res_ready;
    // Results that will occupy the buffer after this edge, excluding a new accept.
    // occ >= 1 whenever res_pop is set, so this never underflows.
    assign inflight  = {1'b0, occ} + {2'b0, s1_valid} - {2'b0, res_pop};
    assign lkp_ready = run_open && (inflight < 3'd2);
    assign lkp_fire  = lkp_valid && lkp_ready;

    // ------------------------------------------------------------------
    // RAM ports
    // ------------------------------------------------------------------
    assign ram_rd_en   = lkp_fire;
    assign ram_rd_addr = lkp_addr;

    // The sweep owns the write port in INIT; otherwise host updates pass straight through.
    always_comb begin
        ram_wr_en   = 1'b0;
        ram_wr_addr = upd_addr;
        ram_wr_data = upd_data;
        if (state == ST_INIT) begin
            ram_wr_en   = 1'b1;
            ram_wr_addr = sweep_cnt;
            ram_wr_data = INIT_VALUE;
        end else begin
            ram_wr_en   = upd_fire;
        end
    end

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    assign sweep_last = (sweep_cnt == AW'(DEPTH - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            ST_INIT:  if (sweep_last)                      state_nxt = ST_RUN;
            ST_RUN:   if (init_req)                        state_nxt = ST_DRAIN;
            // Every accepted lookup must be delivered before the table is wiped.
            ST_DRAIN: if (!s1_valid && (occ == 2'd0))      state_nxt = ST_INIT;
            default:                                       state_nxt = ST_INIT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_INIT;
            sweep_cnt   <= '0;
            init_done_q <= 1'b0;
        end else begin
            state       <= state_nxt;
            // Counter only advances while sweeping; it sits at 0 otherwise so a
            // new sweep always starts from the first entry.
            sweep_cnt   <= ((state == ST_INIT) && !sweep_last) ? sweep_cnt + AW'(1) : '0;
            init_done_q <= (state == ST_INIT) && sweep_last;
        end
    end

    assign init_busy = (state != ST_RUN);
    assign init_done = init_done_q;

    // ------------------------------------------------------------------
    // Lookup pipeline
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_addr  <= '0;
        end else begin
            s1_valid <= lkp_fire;
            s1_addr  <= lkp_addr;
        end
    end

`ifdef BYPASS_FWD_EN
    // The RAM reads first on a same-address collision, so the new data is
    // captured here and substituted when the read data comes back.
    logic              s1_fwd;
    logic [DWIDTH-1:0] s1_fwd_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_fwd      <= 1'b0;
            s1_fwd_data <= '0;
        end else begin
            s1_fwd      <= upd_fire && lkp_fire && (upd_addr == lkp_addr);
            s1_fwd_data <= upd_data;
        end
    end

    assign s1_data = s1_fwd ? s1_fwd_data : ram_rd_data;
`else
    assign s1_data = ram_rd_data;
`endif

    // Two entries cover the full round trip of the ready decision, so one
    // lookup per cycle is sustained while res_ready stays high.
    ht_fifo #(
        .WIDTH (AW + DWIDTH),
        .DEPTH (2)
    ) u_res_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_vld (s1_valid),
        .push_dat ({s1_addr, s1_data}),
        .pop_rdy  (res_ready),
        .head_vld (res_valid),
        .head_dat (fifo_head),
        .occ      (occ)
    );

    assign res_addr = fifo_head[AW+DWIDTH-1:DWIDTH];
    assign res_data = fifo_head[DWIDTH-1:0];
endmodule

// File: tb/tb_hash_table_ram_ctrl.sv
module tb_hash_table_ram_ctrl;
    localparam int DWIDTH = 64;
    localparam int DEPTH  = 512;
    localparam int AW     = 9;
    localparam logic [DWIDTH-1:0] INIT_VALUE = '0;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              upd_valid = 1'b0;
    logic              upd_ready;
    logic [AW-1:0]     upd_addr = '0;
    logic [DWIDTH-1:0] upd_data = '0;
    logic              lkp_valid = 1'b0;
    logic              lkp_ready;
    logic [AW-1:0]     lkp_addr = '0;
    logic              res_valid;
    logic              res_ready = 1'b0;
    logic [AW-1:0]     res_addr;
    logic [DWIDTH-1:0] res_data;
    logic              init_req = 1'b0;
    logic              init_busy;
    logic              init_done;
    logic              ram_wr_en;
    logic [AW-1:0]     ram_wr_addr;
    logic [DWIDTH-1:0] ram_wr_data;
    logic              ram_rd_en;
    logic [AW-1:0]     ram_rd_addr;
    logic [DWIDTH-1:0] ram_rd_data = '0;

    always #5 clk = ~clk;

    hash_table_ram_ctrl #(
        .DWIDTH(DWIDTH), .DEPTH(DEPTH), .INIT_VALUE(INIT_VALUE)
    ) dut (
        .clk(clk), .rst(rst),
        .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_addr(upd_addr), .upd_data(upd_data),
        .lkp_valid(lkp_valid), .lkp_ready(lkp_ready), .lkp_addr(lkp_addr),
        .res_valid(res_valid), .res_ready(res_ready), .res_addr(res_addr), .res_data(res_data),
        .init_req(init_req), .init_busy(init_busy), .init_done(init_done),
        .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
        .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data)
    );

    // Simple dual-port RAM, registered read, read-first on a same-address write.
    logic [DWIDTH-1:0] ram [DEPTH];
    always @(posedge clk) begin
        if (ram_wr_en) ram[ram_wr_addr] <= ram_wr_data;
        if (ram_rd_en) ram_rd_data <= ram[ram_rd_addr];
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the table as a plain array plus an in-order queue of answers.
    typedef struct {
        logic [AW-1:0]     addr;
        logic [DWIDTH-1:0] data;
    } exp_t;

    exp_t              exp_q[$];
    logic [DWIDTH-1:0] ref_mem [DEPTH];

    always @(negedge clk) begin : model
        exp_t e;
        if (rst) begin
            exp_q.delete();
            foreach (ref_mem[j]) ref_mem[j] = INIT_VALUE;
        end else begin
            if (lkp_valid && lkp_ready) begin
                e.addr = lkp_addr;
                e.data = ref_mem[lkp_addr];
`ifdef BYPASS_FWD_EN
                if (upd_valid && upd_ready && (upd_addr == lkp_addr)) e.data = upd_data;
`endif
                exp_q.push_back(e);
            end
            if (upd_valid && upd_ready) ref_mem[upd_addr] = upd_data;
            // A clear request always ends with a full wipe before any later lookup is accepted.
            if (init_req) foreach (ref_mem[j]) ref_mem[j] = INIT_VALUE;
        end
    end

    // Monitor: pops one expectation per consumed result and checks stall stability.
    logic              hold_v = 1'b0;
    logic [AW-1:0]     hold_a;
    logic [DWIDTH-1:0] hold_d;

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                chk("res_hold_valid", 64'(res_valid), 64'd1);
                chk("res_hold_addr", 64'(res_addr), 64'(hold_a));
                chk("res_hold_data", res_data, hold_d);
            end
            hold_v = res_valid && !res_ready;
            hold_a = res_addr;
            hold_d = res_data;
            if (res_valid && res_ready) begin
                chk("res_expected_pending", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("res_addr", 64'(res_addr), 64'(e.addr));
                    chk("res_data", res_data, e.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called at a negedge inside the first sweep cycle; returns at a negedge.
    task automatic sweep_chk();
        for (int i = 0; i < DEPTH; i++) begin
            chk("sweep_addr", 64'(ram_wr_addr), 64'(i));
            chk("sweep_ctl", 64'({ram_wr_en, init_busy, upd_ready, lkp_ready, init_done,
                                  ram_wr_data == INIT_VALUE}), 64'b110001);
            tick();
            if (i < DEPTH - 1) begin
                // Requests during the sweep must be held off.
                upd_valid = 1'($urandom_range(0, 1));
                upd_addr  = AW'($urandom_range(0, DEPTH - 1));
                upd_data  = {$urandom, $urandom};
                lkp_valid = 1'($urandom_range(0, 1));
                lkp_addr  = AW'($urandom_range(0, DEPTH - 1));
            end else begin
                upd_valid = 1'b0;
                lkp_valid = 1'b0;
            end
            @(negedge clk);
        end
        chk("done_pulse", 64'({init_done, init_busy, upd_ready, lkp_ready}), 64'b1011);
        tick();
        @(negedge clk);
        chk("done_once", 64'(init_done), 64'd0);
    endtask

    task automatic wait_drain(input string name);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !res_valid) break;
            @(posedge clk);
        end
        chk(name, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        int acc;
        int nxt;

        // ---------------- reset values ----------------
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ctl", 64'({init_busy, res_valid, init_done, upd_ready, lkp_ready}), 64'b10000);
        chk("rst_wr_addr", 64'(ram_wr_addr), 64'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        sweep_chk();

        // ---------------- update then lookup ----------------
        tick();
        upd_valid = 1'b1; upd_addr = AW'(5); upd_data = 64'hDEAD; res_ready = 1'b1;
        @(negedge clk);
        chk("upd_accept", 64'({upd_ready, ram_wr_en, ram_wr_addr == AW'(5), ram_wr_data == 64'hDEAD}), 64'b1111);
        tick();
        upd_valid = 1'b0; lkp_valid = 1'b1; lkp_addr = AW'(5);
        @(negedge clk);
        chk("lkp_accept", 64'({lkp_ready, ram_rd_en, ram_rd_addr == AW'(5)}), 64'b111);
        tick();
        lkp_valid = 1'b0;
        @(negedge clk);
        chk("lat_n1", 64'(res_valid), 64'd0);
        tick();
        @(negedge clk);
        chk("lat_n2_valid", 64'(res_valid), 64'd1);
        chk("lat_n2_addr", 64'(res_addr), 64'd5);
        chk("lat_n2_data", res_data, 64'hDEAD);

        // ---------------- back-to-back lookups ----------------
        tick();
        for (int i = 0; i < 16; i++) begin
            lkp_valid = 1'b1; lkp_addr = AW'(i);
            @(negedge clk);
            chk("b2b_ready", 64'(lkp_ready), 64'd1);
            if (i >= 2) chk("b2b_res", 64'({res_valid, res_addr}), 64'({1'b1, AW'(i - 2)}));
            tick();
        end
        lkp_valid = 1'b0;
        @(negedge clk);
        chk("b2b_res14", 64'({res_valid, res_addr}), 64'({1'b1, AW'(14)}));
        tick();
        @(negedge clk);
        chk("b2b_res15", 64'({res_valid, res_addr}), 64'({1'b1, AW'(15)}));
        tick();
        @(negedge clk);
        chk("b2b_idle", 64'(res_valid), 64'd0);

        // ---------------- backpressure ----------------
        tick();
        res_ready = 1'b0; acc = 0; nxt = 32;
        for (int k = 0; k < 6; k++) begin
            lkp_valid = 1'b1; lkp_addr = AW'(nxt);
            @(negedge clk);
            if (lkp_ready) begin acc++; nxt++; end
            tick();
        end
        @(negedge clk);
        chk("bp_accepts", 64'(acc), 64'd2);
        chk("bp_ready_low", 64'(lkp_ready), 64'd0);
        tick();
        lkp_valid = 1'b0; res_ready = 1'b1;
        wait_drain("bp_drain");

        // ---------------- same-cycle collision ----------------
        tick();
        upd_valid = 1'b1; upd_addr = AW'(7); upd_data = 64'h1234;
        lkp_valid = 1'b1; lkp_addr = AW'(7); res_ready = 1'b1;
        @(negedge clk);
        chk("col_accept", 64'({upd_ready, lkp_ready}), 64'b11);
        tick();
        upd_valid = 1'b0; lkp_valid = 1'b0;
        @(negedge clk);
        tick();
        @(negedge clk);
        chk("col_res_addr", 64'({res_valid, res_addr}), 64'({1'b1, AW'(7)}));
`ifdef BYPASS_FWD_EN
        chk("col_res_data", res_data, 64'h1234);
`else
        chk("col_res_data", res_data, 64'h0);
`endif

        // ---------------- clear request with results pending ----------------
        tick();
        res_ready = 1'b0; lkp_valid = 1'b1; lkp_addr = AW'(5);
        @(negedge clk);
        chk("drn_lkp0", 64'(lkp_ready), 64'd1);
        tick();
        lkp_addr = AW'(7);
        @(negedge clk);
        chk("drn_lkp1", 64'(lkp_ready), 64'd1);
        tick();
        lkp_valid = 1'b0; init_req = 1'b1;
        upd_valid = 1'b1; upd_addr = AW'(9); upd_data = 64'h5555;
        @(negedge clk);
        chk("req_closes_ports", 64'({upd_ready, lkp_ready, ram_wr_en}), 64'b000);
        for (int k = 0; k < 8; k++) begin
            tick();
            @(negedge clk);
            chk("drain_hold", 64'({init_busy, ram_wr_en, upd_ready, lkp_ready, res_valid}), 64'b10001);
            chk("drain_head", 64'(res_addr), 64'd5);
        end
        tick();
        res_ready = 1'b1; init_req = 1'b0; upd_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (ram_wr_en) break;
            tick();
        end
        chk("drain_to_init", 64'(ram_wr_en), 64'd1);
        sweep_chk();

        tick();
        lkp_valid = 1'b1; lkp_addr = AW'(5);
        @(negedge clk);
        chk("post_clr_accept", 64'(lkp_ready), 64'd1);
        tick();
        lkp_valid = 1'b0;
        @(negedge clk);
        tick();
        @(negedge clk);
        chk("post_clr_res", 64'({res_valid, res_addr}), 64'({1'b1, AW'(5)}));
        chk("post_clr_data", res_data, INIT_VALUE);

        // ---------------- randomized traffic ----------------
        for (int c = 0; c < 1500; c++) begin
            tick();
            upd_valid = 1'($urandom_range(0, 1));
            upd_addr  = AW'($urandom_range(0, 15));
            upd_data  = {$urandom, $urandom};
            lkp_valid = ($urandom_range(0, 3) != 0);
            lkp_addr  = AW'($urandom_range(0, 15));
            res_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
        end
        tick();
        upd_valid = 1'b0; lkp_valid = 1'b0; res_ready = 1'b1;
        wait_drain("rand_drain");

        // ---------------- reset mid-sweep ----------------
        tick();
        init_req = 1'b1;
        @(negedge clk);
        tick();
        init_req = 1'b0;
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            if (ram_wr_en && init_busy && ram_wr_addr == AW'(200)) break;
            tick();
        end
        chk("abort_point", 64'({ram_wr_en, ram_wr_addr}), 64'({1'b1, AW'(200)}));
        #1 rst = 1'b1;
        #1;
        chk("abort_rst_ctl", 64'({init_busy, res_valid, init_done, upd_ready, lkp_ready}), 64'b10000);
        chk("abort_rst_addr", 64'(ram_wr_addr), 64'd0);
        @(posedge clk);
        tick();
        rst = 1'b0;
        @(negedge clk);
        sweep_chk();

        tick();
        lkp_valid = 1'b1; lkp_addr = AW'(200);
        @(negedge clk);
        tick();
        lkp_valid = 1'b0;
        wait_drain("final_drain");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
